operand_entry: RTL and testbench
================================

// Module: operand_entry
// PURPOSE
//   Input side of the DE10-Lite adder/display path.
//   - Synchronises and debounces the two active-low push-buttons.
//   - Runs an entry FSM that captures operand A, then operand B, from the switches.
//   - Presents both operands with a VALID flag to the ripple-carry adder.
//   The adder result then goes on to the SevenSegment decoder.
//
// PARAMETERS
//   WIDTH            4       operand width; operands are taken from SW[WIDTH-1:0]
//   DEBOUNCE_CYCLES  500000  consecutive stable cycles needed to accept a key change
//                            (10 ms at 50 MHz); legal minimum 2
//
// PORTS
//   MAX10_CLK1_50  in   1      sole clock, 50 MHz board oscillator
//   RST            in   1      synchronous, active-high reset
//   SW             in   WIDTH  operand source switches; asynchronous, sampled when a capture occurs
//   KEY            in   2      KEY[0] = ENTER, KEY[1] = CLEAR; active-low (0 = pressed), asynchronous
//   OPA            out  WIDTH  captured operand A (to adder X)
//   OPB            out  WIDTH  captured operand B (to adder Y)
//   VALID          out  1      high while OPA/OPB form a complete, stable pair
//   STATE          out  2      FSM state: 00 GET_A, 01 GET_B, 10 SHOW
//
// BEHAVIOUR
// - Reset, synchronous to MAX10_CLK1_50 with RST high:
//     sync flops and debounced levels = 1 (released); counters = 0;
//     STATE = GET_A; OPA = 0; OPB = 0; VALID = 0.
//   Reset mid-operation discards any partial entry and any in-flight press.
// - Per key, identical logic for KEY[0] and KEY[1]:
//     s1 <= KEY; s2 <= s1                          (2-flop synchroniser)
//     if s2 == deb:                       cnt <= 0
//     else if cnt == DEBOUNCE_CYCLES-1:   deb <= s2; cnt <= 0
//     else:                               cnt <= cnt+1
//     deb_d <= deb;  press = deb_d & ~deb           (exactly one cycle per press)
//   cnt width = $clog2(DEBOUNCE_CYCLES).
//   A glitch or bounce shorter than DEBOUNCE_CYCLES cycles (measured at s2) produces no press.
//   A held key produces exactly one press. Release produces no event.
// - Latency: a clean key fall is acted on at the (DEBOUNCE_CYCLES+3)th rising edge
//   after KEY goes low; SW is sampled at that same edge.
// - FSM, evaluated on edges where a press is high:
//     GET_A + ENTER : OPA <= SW; OPB <= 0; -> GET_B
//     GET_B + ENTER : OPB <= SW; -> SHOW; VALID <= 1 (same edge)
//     SHOW  + ENTER : VALID <= 0; -> GET_A; OPA/OPB hold their values
//     any   + CLEAR : OPA <= 0; OPB <= 0; VALID <= 0; -> GET_A
//   CLEAR and ENTER pressed on the same edge: CLEAR wins and ENTER is dropped.
//   State 11 is unreachable; if entered, recover to GET_A with the CLEAR actions.
// - SW changes outside a capture edge have no effect; OPA/OPB never track SW
//   continuously.
// - VALID is a registered level. OPA and OPB are stable for the whole time VALID = 1.
// - No arithmetic is done in this block. Operands pass through unsigned at WIDTH bits.
//
// TESTING  (DEBOUNCE_CYCLES=4, WIDTH=4; "press" = KEY low >= 10 cycles, then high)
// 1. RST high 2 cycles -> OPA=0, OPB=0, VALID=0, STATE=00.
// 2. SW=4'h3, press ENTER -> OPA=3 exactly at edge 7 after the KEY fall; STATE=01.
//    Then SW=4'h5, press ENTER -> OPB=5, VALID=1, STATE=10.
// 3. KEY[0] low for 3 cycles, repeated with 1-cycle high gaps (bounce) -> no capture.
//    Then hold low 10 cycles -> exactly one capture.
// 4. Hold ENTER low for 100 cycles in GET_A -> one transition only; STATE=01; OPB=0.
// 5. In SHOW (OPA=3, OPB=5): CLEAR and ENTER fall on the same cycle
//    -> OPA=0, OPB=0, VALID=0, STATE=00.
// 6. RST asserted while in GET_B with OPA=9 -> next edge OPA=0, STATE=00.
//    A press already in the synchroniser is lost.

Source files
------------

// File: rtl/operand_entry.sv
// Operand entry front end: synchronises and debounces the two active-low keys,
// then steps through capturing operand A and operand B from the switches.
module operand_entry #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             MAX10_CLK1_50,
    input  logic             RST,
    input  logic [WIDTH-1:0] SW,
    input  logic [1:0]       KEY,
    output logic [WIDTH-1:0] OPA,
    output logic [WIDTH-1:0] OPB,
    output logic             VALID,
    output logic [1:0]       STATE
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        GET_A = 2'b00,
        GET_B = 2'b01,
        SHOW  = 2'b10
    } state_t;

    logic [1:0]    s1;
    logic [1:0]    s2;
    logic [1:0]    deb;
    logic [1:0]    deb_d;
    logic [CW-1:0] cnt [2];
    logic [1:0]    press;
    logic          enter;
    logic          clear;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opa_next;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] opb_next;
    logic             valid;
    logic             valid_next;

    // A key level is accepted only after it has differed from the debounced
    // level for DEBOUNCE_CYCLES consecutive cycles at the synchroniser output.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (RST) begin
            s1    <= 2'b11;
            s2    <= 2'b11;
            deb   <= 2'b11;
            deb_d <= 2'b11;
            for (int k = 0; k < 2; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            s1    <= KEY;
            s2    <= s1;
            deb_d <= deb;
            for (int k = 0; k < 2; k++) begin
                if (s2[k] == deb[k]) begin
                    cnt[k] <= '0;
                end else if (cnt[k] == CNT_MAX) begin
                    deb[k] <= s2[k];
                    cnt[k] <= '0;
                end else begin
                    cnt[k] <= cnt[k] + CW'(1);
                end
            end
        end
    end

    assign press = deb_d & ~deb;
    assign enter = press[0];
    assign clear = press[1];

    always_ff @(posedge MAX10_CLK1_50) begin
        if (RST) begin
            state <= GET_A;
            opa   <= '0;
            opb   <= '0;
            valid <= 1'b0;
        end else begin
            state <= state_next;
            opa   <= opa_next;
            opb   <= opb_next;
            valid <= valid_next;
        end
    end

    // CLEAR outranks ENTER; the unused encoding falls back to the clear actions.
    always_comb begin
        state_next = state;
        opa_next   = opa;
        opb_next   = opb;
        valid_next = valid;
        case (state)
            GET_A, GET_B, SHOW: begin
                if (clear) begin
                    state_next = GET_A;
                    opa_next   = '0;
                    opb_next   = '0;
                    valid_next = 1'b0;
                end else if (enter) begin
                    case (state)
                        GET_A: begin
                            opa_next   = SW;
                            opb_next   = '0;
                            state_next = GET_B;
                        end
                        GET_B: begin
                            opb_next   = SW;
                            valid_next = 1'b1;
                            state_next = SHOW;
                        end
                        default: begin
                            valid_next = 1'b0;
                            state_next = GET_A;
                        end
                    endcase
                end
            end
            default: begin
                state_next = GET_A;
                opa_next   = '0;
                opb_next   = '0;
                valid_next = 1'b0;
            end
        endcase
    end

    assign OPA   = opa;
    assign OPB   = opb;
    assign VALID = valid;
    assign STATE = state;

endmodule

// File: tb/tb_operand_entry.sv
// Scoreboard bench for operand_entry: a behavioural model predicts the operand
// pair after each key action; the queued expectation is compared once the DUT settles.
module tb_operand_entry;

    logic       clk;
    logic       rst;
    logic [3:0] sw;
    logic [1:0] key;
    logic [3:0] opa;
    logic [3:0] opb;
    logic       valid;
    logic [1:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] opa;
        logic [3:0] opb;
        logic       valid;
        logic [1:0] state;
    } snap_t;

    snap_t expQ[$];

    logic [3:0] mOpa;
    logic [3:0] mOpb;
    logic       mValid;
    logic [1:0] mState;

    operand_entry #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
        .MAX10_CLK1_50(clk),
        .RST          (rst),
        .SW           (sw),
        .KEY          (key),
        .OPA          (opa),
        .OPB          (opb),
        .VALID        (valid),
        .STATE        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mOpa   = 4'h0;
        mOpb   = 4'h0;
        mValid = 1'b0;
        mState = 2'b00;
    endtask

    task automatic modelPress(input logic enter, input logic clr, input logic [3:0] swVal);
        if (clr) begin
            modelReset();
        end else if (enter) begin
            case (mState)
                2'b00: begin mOpa = swVal; mOpb = 4'h0; mState = 2'b01; end
                2'b01: begin mOpb = swVal; mValid = 1'b1; mState = 2'b10; end
                default: begin mValid = 1'b0; mState = 2'b00; end
            endcase
        end
    endtask

    task automatic pushExpected();
        snap_t s;
        s.opa   = mOpa;
        s.opb   = mOpb;
        s.valid = mValid;
        s.state = mState;
        expQ.push_back(s);
    endtask

    task automatic compareTop(input string tag);
        snap_t e;
        if (expQ.size() == 0) begin
            checkOutput({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            checkOutput({tag, "_opa"},   32'(opa),   32'(e.opa));
            checkOutput({tag, "_opb"},   32'(opb),   32'(e.opb));
            checkOutput({tag, "_valid"}, 32'(valid), 32'(e.valid));
            checkOutput({tag, "_state"}, 32'(state), 32'(e.state));
        end
    endtask

    // Hold the masked keys low for lowCycles cycles, then release and let the release settle.
    task automatic applyStimulus(input logic [1:0] mask, input int lowCycles, input logic [3:0] swVal);
        @(negedge clk);
        sw = swVal;
        modelPress(mask[0], mask[1], swVal);
        pushExpected();
        key = ~mask;
        repeat (lowCycles) @(negedge clk);
        key = 2'b11;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        sw  = 4'h0;
        key = 2'b11;
        modelReset();
        repeat (2) @(negedge clk);
        pushExpected();
        compareTop("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // First ENTER: check the exact capture edge
        sw     = 4'h3;
        key[0] = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        checkOutput("lat_edge6_opa", 32'(opa), 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("lat_edge7_opa", 32'(opa), 32'h3);
        checkOutput("lat_edge7_state", 32'(state), 32'h1);
        repeat (3) @(negedge clk);
        key = 2'b11;
        repeat (12) @(negedge clk);
        modelPress(1'b1, 1'b0, 4'h3);
        pushExpected();
        compareTop("enter_a");

        sw = 4'hF;
        repeat (5) @(negedge clk);
        pushExpected();
        compareTop("sw_no_track");

        applyStimulus(2'b01, 10, 4'h5);
        compareTop("enter_b");

        // Bounce in SHOW: low 3 cycles with 1-cycle high gaps must not register
        pushExpected();
        for (int i = 0; i < 4; i++) begin
            key[0] = 1'b0;
            repeat (3) @(negedge clk);
            key[0] = 1'b1;
            @(negedge clk);
        end
        repeat (10) @(negedge clk);
        compareTop("bounce");

        applyStimulus(2'b01, 10, 4'h8);
        compareTop("show_enter");

        applyStimulus(2'b01, 100, 4'h3);
        compareTop("held_enter");

        applyStimulus(2'b01, 10, 4'h5);
        compareTop("show_again");

        applyStimulus(2'b11, 10, 4'h6);
        compareTop("clear_wins");

        applyStimulus(2'b01, 10, 4'h9);
        compareTop("enter_a9");

        // Reset with a press in the synchroniser
        @(negedge clk);
        key[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        key = 2'b11;
        @(negedge clk);
        checkOutput("rst_mid_opa", 32'(opa), 32'h0);
        checkOutput("rst_mid_state", 32'(state), 32'h0);
        rst = 1'b0;
        modelReset();
        repeat (20) @(negedge clk);
        pushExpected();
        compareTop("press_lost");

        applyStimulus(2'b01, 10, 4'hA);
        compareTop("enter_aA");
        applyStimulus(2'b10, 10, 4'h1);
        compareTop("clear_only");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
